// File: rtl/baud_pkg.sv
// Shared state encoding and default sizing for the fractional baud generator.
package baud_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BAUD_DIV_W   = 16;
  localparam int BAUD_FRAC_W  = 4;
  localparam int BAUD_OSR     = 16;
  localparam int BAUD_DEF_DIV = 16;

endpackage

// File: rtl/baud_gen_if.sv
// Control and status bundle between a UART-style client and the baud generator.
interface baud_gen_if
  import baud_pkg::*;
#(
  parameter int DIV_W  = BAUD_DIV_W,
  parameter int FRAC_W = BAUD_FRAC_W
);

  logic              en;
  logic              load;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              tick;
  logic              bclk;
  logic              busy;
  logic              cfg_err;

  modport master (
    output en, load, div_int, div_frac,
    input  tick, bclk, busy, cfg_err
  );

  modport slave (
    input  en, load, div_int, div_frac,
    output tick, bclk, busy, cfg_err
  );

endinterface

// File: rtl/baud_frac_acc.sv
// Fraction accumulator: adds the fractional divisor once per period and
// registers the carry that stretches the following period by one cycle.
module baud_frac_acc
  import baud_pkg::*;
#(
  parameter int FRAC_W = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  output logic              carry
);

  logic [FRAC_W-1:0] acc;
  logic [FRAC_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, frac};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (step) begin
      acc   <= sum[FRAC_W-1:0];
      carry <= sum[FRAC_W];
    end
  end

endmodule

// File: rtl/baud_gen.sv
// Fractional-N baud generator: one-cycle oversample tick every div_int(+carry)
// cycles and a 50% duty bclk toggling every OSR/2 ticks.
module baud_gen
  import baud_pkg::*;
#(
  parameter int DIV_W   = BAUD_DIV_W,
  parameter int FRAC_W  = BAUD_FRAC_W,
  parameter int OSR     = BAUD_OSR,
  parameter int DEF_DIV = BAUD_DEF_DIV
) (
  input logic       clk,
  input logic       rst_n,
  baud_gen_if.slave bus
);

  localparam int TCNT_W = $clog2(OSR);
  localparam logic [TCNT_W-1:0] TCNT_HALF = TCNT_W'(OSR / 2 - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OSR - 1);

  state_t            state;
  state_t            next_state;
  logic [DIV_W-1:0]  div_act;
  logic [DIV_W-1:0]  div_shadow;
  logic [FRAC_W-1:0] frac_act;
  logic [FRAC_W-1:0] frac_shadow;
  logic              pending;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W:0]    p_last;
  logic [TCNT_W-1:0] tcnt;
  logic              carry;
  logic              active;
  logic              period_end;
  logic              load_ok;
  logic              load_bad;
  logic              tick_q;
  logic              bclk_q;
  logic              cfg_err_q;

  assign load_ok    = bus.load && (bus.div_int != '0);
  assign load_bad   = bus.load && (bus.div_int == '0);
  assign active     = (state == RUN) && bus.en;
  // Carry from the previous tick lengthens the current period by one cycle.
  assign p_last     = {1'b0, div_act} + {{DIV_W{1'b0}}, carry} - (DIV_W + 1)'(1);
  assign period_end = active && ({1'b0, cnt} == p_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.en && (div_act != '0)) next_state = RUN;
      RUN:  if (!bus.en) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state == RUN);
    bus.tick    = tick_q;
    bus.bclk    = bclk_q;
    bus.cfg_err = cfg_err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      tcnt   <= '0;
      tick_q <= 1'b0;
      bclk_q <= 1'b0;
    end else if (!active) begin
      cnt    <= '0;
      tcnt   <= '0;
      tick_q <= 1'b0;
      bclk_q <= 1'b0;
    end else begin
      tick_q <= period_end;
      if (period_end) begin
        cnt  <= '0;
        tcnt <= (tcnt == TCNT_LAST) ? '0 : tcnt + TCNT_W'(1);
        if ((tcnt == TCNT_HALF) || (tcnt == TCNT_LAST)) bclk_q <= !bclk_q;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  // Loads in RUN wait in the shadow until a period boundary so a period is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_act     <= DIV_W'(DEF_DIV);
      frac_act    <= '0;
      div_shadow  <= '0;
      frac_shadow <= '0;
      pending     <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      if (load_ok)       cfg_err_q <= 1'b0;
      else if (load_bad) cfg_err_q <= 1'b1;
      if ((state == IDLE) || period_end) begin
        if (load_ok) begin
          div_act  <= bus.div_int;
          frac_act <= bus.div_frac;
        end else if (pending) begin
          div_act  <= div_shadow;
          frac_act <= frac_shadow;
        end
        pending <= 1'b0;
      end else if (load_ok) begin
        div_shadow  <= bus.div_int;
        frac_shadow <= bus.div_frac;
        pending     <= 1'b1;
      end
    end
  end

  baud_frac_acc #(
    .FRAC_W(FRAC_W)
  ) u_frac_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(!active),
    .step (period_end),
    .frac (frac_act),
    .carry(carry)
  );

endmodule

// File: tb/tb_baud_gen.sv
// Directed self-checking bench for baud_gen: spacing, fractional pattern,
// shadowed loads, rejected loads, enable drop and asynchronous reset.
module tb_baud_gen;
  import baud_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   total;

  baud_gen_if #(.DIV_W(16), .FRAC_W(4)) bus ();

  baud_gen #(
    .DIV_W  (16),
    .FRAC_W (4),
    .OSR    (16),
    .DEF_DIV(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Cycles until the next sampled tick; -1 if none within the budget.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.tick && cycles < 200);
    if (!bus.tick) cycles = -1;
  endtask

  task automatic apply_stimulus(input logic [15:0] d, input logic [3:0] f);
    bus.div_int  = d;
    bus.div_frac = f;
    bus.load     = 1'b1;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    #12;
    check_output("reset_tick", 32'(bus.tick), 0);
    check_output("reset_bclk", 32'(bus.bclk), 0);
    check_output("reset_busy", 32'(bus.busy), 0);
    check_output("reset_cfg_err", 32'(bus.cfg_err), 0);
    rst_n = 1'b1;
    step(1);

    // div 4, frac 0: spacing and bclk period
    apply_stimulus(16'd4, 4'd0);
    check_output("cfg_err_valid_load", 32'(bus.cfg_err), 0);
    bus.en = 1'b1;
    step(1);
    check_output("busy_run", 32'(bus.busy), 1);
    wait_tick(n);
    check_output("first_tick_div4", n, 4);
    total = 0;
    for (int i = 2; i <= 24; i++) begin
      wait_tick(n);
      check_output("spacing_div4", n, 4);
      if (i == 7)  check_output("bclk_before_half", 32'(bus.bclk), 0);
      if (i == 8)  check_output("bclk_rise", 32'(bus.bclk), 1);
      if (i == 16) check_output("bclk_fall", 32'(bus.bclk), 0);
      if (i == 24) check_output("bclk_rise2", 32'(bus.bclk), 1);
      if (i > 8) total += n;
    end
    check_output("bclk_period", total, 64);

    // div 4 + 8/16: alternating 4,5 after the first tick
    bus.en = 1'b0;
    step(1);
    check_output("idle_busy", 32'(bus.busy), 0);
    apply_stimulus(16'd4, 4'd8);
    bus.en = 1'b1;
    step(1);
    wait_tick(n);
    check_output("first_tick_frac", n, 4);
    total = 0;
    for (int i = 0; i < 16; i++) begin
      wait_tick(n);
      if (i == 0) check_output("frac_spacing_a", n, 4);
      if (i == 1) check_output("frac_spacing_b", n, 5);
      total += n;
    end
    check_output("frac_16_tick_span", total, 72);

    // mid-period load in RUN waits for the next tick
    bus.en = 1'b0;
    step(1);
    apply_stimulus(16'd4, 4'd0);
    bus.en = 1'b1;
    step(1);
    wait_tick(n);
    check_output("first_tick_div4b", n, 4);
    apply_stimulus(16'd6, 4'd0);
    wait_tick(n);
    check_output("period_before_load", n + 1, 4);
    wait_tick(n);
    check_output("period_after_load", n, 6);
    wait_tick(n);
    check_output("period_after_load2", n, 6);

    // rejected load keeps divisor, later valid load clears the flag
    apply_stimulus(16'd0, 4'd0);
    check_output("cfg_err_set", 32'(bus.cfg_err), 1);
    wait_tick(n);
    check_output("spacing_after_bad_load", n + 1, 6);
    wait_tick(n);
    check_output("spacing_after_bad_load2", n, 6);
    apply_stimulus(16'd6, 4'd0);
    check_output("cfg_err_cleared", 32'(bus.cfg_err), 0);
    wait_tick(n);
    check_output("spacing_after_good_load", n + 1, 6);

    // en drop mid-period at div 10
    bus.en = 1'b0;
    step(1);
    apply_stimulus(16'd10, 4'd0);
    bus.en = 1'b1;
    step(1);
    wait_tick(n);
    check_output("first_tick_div10", n, 10);
    for (int i = 2; i <= 8; i++) begin
      wait_tick(n);
      check_output("spacing_div10", n, 10);
    end
    check_output("bclk_high_div10", 32'(bus.bclk), 1);
    step(3);
    bus.en = 1'b0;
    step(1);
    check_output("en_low_busy", 32'(bus.busy), 0);
    check_output("en_low_tick", 32'(bus.tick), 0);
    check_output("en_low_bclk", 32'(bus.bclk), 0);
    bus.en = 1'b1;
    step(1);
    wait_tick(n);
    check_output("reenable_first_tick", n, 10);

    // asynchronous reset mid-run, then restart at the default divisor
    for (int i = 2; i <= 8; i++) begin
      wait_tick(n);
      check_output("spacing_div10_b", n, 10);
    end
    check_output("bclk_high_before_reset", 32'(bus.bclk), 1);
    apply_stimulus(16'd0, 4'd0);
    check_output("cfg_err_before_reset", 32'(bus.cfg_err), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset_tick", 32'(bus.tick), 0);
    check_output("async_reset_bclk", 32'(bus.bclk), 0);
    check_output("async_reset_busy", 32'(bus.busy), 0);
    check_output("async_reset_cfg_err", 32'(bus.cfg_err), 0);
    #2;
    rst_n = 1'b1;
    step(1);
    wait_tick(n);
    check_output("def_div_first_tick", n, 16);
    wait_tick(n);
    check_output("def_div_spacing", n, 16);

    // div 1: tick held high
    bus.en = 1'b0;
    step(1);
    apply_stimulus(16'd1, 4'd0);
    bus.en = 1'b1;
    step(1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check_output("div1_tick_continuous", 32'(bus.tick), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
